// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with valid/ready byte streams and per-frame error sidebands.
// Define UART_BREAK_DETECT_EN to swallow break frames and pulse rx_break instead of delivering them.
module uart_core #(
  parameter int CLK_HZ     = 12_500_000,
  parameter int BAUDRATE   = 115200,
  parameter int SYNC_DEPTH = 3,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_break,
  output logic                 uart_tx,
  input  logic                 uart_rx
);
  localparam int OS = CLK_HZ / BAUDRATE;
  localparam int CW = $clog2(OS);
  localparam logic [CW-1:0] TOP = CW'(OS - 1);
  localparam logic [CW-1:0] MID = CW'(OS / 2);
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  localparam bit HAS_PAR = PARITY != 0;
  localparam bit ODD = PARITY == 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
  state_t tx_st, tx_st_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [3:0] tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sr, tx_sr_n;
  logic tx_par, tx_par_n, tx_line;
  assign tx_ready = tx_st == IDLE && !rst;
  always_comb begin
    tx_st_n = tx_st;
    tx_cnt_n = tx_cnt == '0 ? TOP : tx_cnt - 1'b1;
    tx_bit_n = tx_bit;
    tx_sr_n = tx_sr;
    tx_par_n = tx_par;
    unique case (tx_st)
      IDLE: if (tx_valid) begin
        tx_st_n = START;
        tx_cnt_n = TOP;
        tx_sr_n = tx_data;
        tx_par_n = ^tx_data ^ ODD;
      end
      START: if (tx_cnt == '0) begin
        tx_st_n = DATA;
        tx_bit_n = '0;
      end
      DATA: if (tx_cnt == '0) begin
        tx_sr_n = tx_sr >> 1;
        tx_bit_n = tx_bit + 1'b1;
        if (tx_bit == LAST_D) begin
          tx_st_n = HAS_PAR ? PAR : STOP;
          tx_bit_n = '0;
        end
      end
      PAR: if (tx_cnt == '0) tx_st_n = STOP;
      STOP: if (tx_cnt == '0) begin
        tx_bit_n = tx_bit + 1'b1;
        if (tx_bit == LAST_S) tx_st_n = IDLE;
      end
      default: tx_st_n = IDLE;
    endcase
    // uart_tx is registered from the next state so the line lines up with the state
    tx_line = tx_st_n == START ? 1'b0 : tx_st_n == DATA ? tx_sr_n[0] : tx_st_n == PAR ? tx_par_n : 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      tx_st <= IDLE;
      uart_tx <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sr <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_st <= tx_st_n;
      uart_tx <= tx_line;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sr <= tx_sr_n;
      tx_par <= tx_par_n;
    end
  logic [SYNC_DEPTH-1:0] sync;
  logic rxd, mid, commit, brk, take;
  state_t rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [3:0] rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sr, rx_sr_n;
  logic ferr, ferr_n, perr, perr_n;
  assign rxd = sync[SYNC_DEPTH-1];
  assign mid = rx_cnt == MID;
  always_comb begin
    rx_st_n = rx_st;
    rx_cnt_n = rx_cnt == '0 ? TOP : rx_cnt - 1'b1;
    rx_bit_n = rx_bit;
    rx_sr_n = rx_sr;
    ferr_n = ferr;
    perr_n = perr;
    commit = 1'b0;
    brk = 1'b0;
    unique case (rx_st)
      IDLE: if (!rxd) begin
        rx_st_n = START;
        rx_cnt_n = TOP;
        ferr_n = 1'b0;
        perr_n = 1'b0;
      end
      START: if (mid && rxd) rx_st_n = IDLE;
        else if (rx_cnt == '0) begin
          rx_st_n = DATA;
          rx_bit_n = '0;
        end
      DATA: begin
        if (mid) rx_sr_n = {rxd, rx_sr[DATA_BITS-1:1]};
        if (rx_cnt == '0) begin
          rx_bit_n = rx_bit + 1'b1;
          if (rx_bit == LAST_D) begin
            rx_st_n = HAS_PAR ? PAR : STOP;
            rx_bit_n = '0;
          end
        end
      end
      PAR: begin
        if (mid) perr_n = (^rx_sr ^ rxd) != ODD;
        if (rx_cnt == '0) rx_st_n = STOP;
      end
      STOP: begin
        if (mid && !rxd) ferr_n = 1'b1;
        // commit at the last stop mid-sample so a slightly fast sender is still caught
        if (mid && rx_bit == LAST_S) begin
          commit = 1'b1;
          rx_st_n = IDLE;
`ifdef UART_BREAK_DETECT_EN
          if (rx_sr == '0 && ferr_n) begin
            brk = 1'b1;
            rx_st_n = BRK;
            rx_cnt_n = TOP;
          end
`endif
        end else if (rx_cnt == '0) rx_bit_n = rx_bit + 1'b1;
      end
`ifdef UART_BREAK_DETECT_EN
      BRK: if (!rxd) rx_cnt_n = TOP;
        else if (rx_cnt == '0) rx_st_n = IDLE;
`endif
      default: rx_st_n = IDLE;
    endcase
  end
  assign take = commit && !brk && (!rx_valid || rx_ready);
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '1;
      rx_st <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sr <= '0;
      ferr <= 1'b0;
      perr <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_frame_err <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun <= 1'b0;
      rx_break <= 1'b0;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], uart_rx};
      rx_st <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sr <= rx_sr_n;
      ferr <= ferr_n;
      perr <= perr_n;
      rx_valid <= take || (rx_valid && !rx_ready);
      if (take) begin
        rx_data <= rx_sr;
        rx_frame_err <= ferr_n;
        rx_parity_err <= perr_n;
      end
      rx_overrun <= commit && !brk && !take;
      rx_break <= brk;
    end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed checks of uart_core in 8N1 (108 clk/bit), 7E2 loopback and 8O1 receive configurations.
module tb_uart_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] a_tx_data = '0, a_rx_data, c_tx_data = '0, c_rx_data;
  logic [6:0] b_tx_data = '0, b_rx_data;
  logic a_tx_valid = 0, a_tx_ready, a_rx_valid, a_rx_ready = 0, a_ferr, a_perr, a_ovr, a_brk, a_tx, a_rx = 1;
  logic b_tx_valid = 0, b_tx_ready, b_rx_valid, b_ferr, b_perr, b_ovr, b_brk, b_tx;
  logic c_tx_valid = 0, c_tx_ready, c_rx_valid, c_rx_ready = 0, c_ferr, c_perr, c_ovr, c_brk, c_tx, c_rx = 1;
  uart_core dut_a (
    .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_frame_err(a_ferr),
    .rx_parity_err(a_perr), .rx_overrun(a_ovr), .rx_break(a_brk), .uart_tx(a_tx), .uart_rx(a_rx));
  uart_core #(.BAUDRATE(781_250), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(1'b1), .rx_frame_err(b_ferr),
    .rx_parity_err(b_perr), .rx_overrun(b_ovr), .rx_break(b_brk), .uart_tx(b_tx), .uart_rx(b_tx));
  uart_core #(.BAUDRATE(781_250), .PARITY(1)) dut_c (
    .clk(clk), .rst(rst), .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready), .rx_frame_err(c_ferr),
    .rx_parity_err(c_perr), .rx_overrun(c_ovr), .rx_break(c_brk), .uart_tx(c_tx), .uart_rx(c_rx));
  int n_chk = 0, n_fail = 0;
  int cyc = 0, ovr_cnt = 0, brk_cnt = 0, lb_n = 0;
  logic [6:0] lb_exp = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) ovr_cnt <= ovr_cnt + int'(a_ovr);
  always @(negedge clk) brk_cnt <= brk_cnt + int'(a_brk);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // loopback scoreboard: bytes must come back in order with clean sidebands
  always @(negedge clk)
    if (b_rx_valid) begin
      check("lb_byte", {23'b0, b_perr, b_ferr, b_rx_data}, {25'b0, lb_exp});
      lb_exp <= lb_exp + 1'b1;
      lb_n <= lb_n + 1;
    end
  task automatic drive(input int w, input int os, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (w == 0) a_rx = f[i]; else c_rx = f[i];
      repeat (os) @(negedge clk);
    end
    if (w == 0) a_rx = 1'b1; else c_rx = 1'b1;
  endtask
  logic [9:0] frame;
  int busy, lat, o0, b0, vcnt, t0, t1, tmo;
  initial begin
    repeat (3) @(negedge clk);
    check("rst_uart_tx", a_tx, 1);
    check("rst_tx_ready", a_tx_ready, 0);
    check("rst_rx_outs", {a_rx_valid, a_ovr, a_brk, a_ferr, a_perr, a_rx_data}, 0);
    rst = 0;
    @(negedge clk);
    check("tx_ready_after_rst", a_tx_ready, 1);
    frame = {1'b1, 8'hA5, 1'b0};
    a_tx_data = 8'hA5;
    a_tx_valid = 1;
    @(negedge clk);
    a_tx_valid = 0;
    busy = 0;
    for (int i = 0; i < 1080; i++) begin
      if (i == 0) check("tx_start_edge", a_tx, 0);
      if (i % 108 == 54) check("tx_bit", a_tx, frame[i/108]);
      busy += int'(!a_tx_ready);
      @(negedge clk);
    end
    check("tx_busy_len", busy, 1080);
    check("tx_ready_back", a_tx_ready, 1);
    check("tx_idle_high", a_tx, 1);
    fork
      drive(0, 108, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
      begin
        lat = 0;
        while (!a_rx_valid && lat < 2000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("rx_latency", lat, 1030);
    check("rx_first", {a_rx_valid, a_ferr, a_perr, a_rx_data}, {3'b100, 8'h11});
    o0 = ovr_cnt;
    drive(0, 108, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
    repeat (5) @(negedge clk);
    check("ovr_keep_data", {a_rx_valid, a_rx_data}, {1'b1, 8'h11});
    check("ovr_pulses", ovr_cnt - o0, 1);
    a_rx_ready = 1;
    @(negedge clk);
    check("rx_valid_fall", a_rx_valid, 0);
    a_rx = 0;
    repeat (20) @(negedge clk);
    a_rx = 1;
    vcnt = 0;
    for (int i = 0; i < 300; i++) begin
      vcnt += int'(a_rx_valid);
      @(negedge clk);
    end
    check("glitch_no_valid", vcnt, 0);
    a_tx_data = 8'h00;
    a_tx_valid = 1;
    @(negedge clk);
    a_tx_valid = 0;
    repeat (300) @(negedge clk);
    check("tx_mid_frame_low", a_tx, 0);
    rst = 1;
    @(negedge clk);
    check("rst_abort_tx", a_tx, 1);
    rst = 0;
    @(negedge clk);
    check("rst_abort_ready", {a_tx_ready, a_tx}, 2'b11);
    a_rx_ready = 0;
    b0 = brk_cnt;
    vcnt = 0;
    a_rx = 0;
    for (int i = 0; i < 3240; i++) begin
      vcnt += int'(a_rx_valid);
      @(negedge clk);
    end
    a_rx = 1;
    for (int i = 0; i < 1200; i++) begin
      vcnt += int'(a_rx_valid);
      @(negedge clk);
    end
`ifdef UART_BREAK_DETECT_EN
    check("brk_pulses", brk_cnt - b0, 1);
    check("brk_no_valid", vcnt, 0);
`else
    check("brk_tied_zero", brk_cnt - b0, 0);
    check("brk_as_data", {a_rx_valid, a_ferr, a_perr, a_rx_data}, {3'b110, 8'h00});
`endif
    a_rx_ready = 1;
    @(negedge clk);
    a_rx_ready = 0;
    drive(1, 16, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    repeat (10) @(negedge clk);
    check("par_err", {c_rx_valid, c_ferr, c_perr, c_rx_data}, {3'b101, 8'h3C});
    c_rx_ready = 1;
    @(negedge clk);
    c_rx_ready = 0;
    drive(1, 16, {5'b0, 1'b0, 1'b1, 8'h55, 1'b0}, 11);
    repeat (40) @(negedge clk);
    check("frame_err", {c_rx_valid, c_ferr, c_perr, c_rx_data}, {3'b110, 8'h55});
    b_tx_valid = 1;
    t0 = 0;
    for (int i = 0; i < 128; i++) begin
      b_tx_data = 7'(i);
      tmo = 0;
      while (!b_tx_ready && tmo < 400) begin
        @(negedge clk);
        tmo++;
      end
      if (i == 0) t0 = cyc;
      t1 = cyc;
      @(negedge clk);
    end
    b_tx_valid = 0;
    check("lb_gap", t1 - t0, 127 * 177);
    repeat (300) @(negedge clk);
    check("lb_count", lb_n, 128);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
